// File: rtl/adpll_tx_serializer_if.sv
// CPU register bus between a host and adpll_tx_serializer.
//   valid   : request strobe (master -> slave)
//   address : register select
//   wdata   : write data
//   wstrb   : 1 = write, 0 = read
//   rdata   : read data, valid with ready (slave -> master)
//   ready   : one-cycle acknowledge
interface adpll_tx_serializer_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
) ();
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/adpll_tx_serializer.sv
// CPU-fed TX bit serializer driving data_mod of adpll_ctr. Words pushed over
// the register bus are queued in a FIFO and shifted out LSB-first, one bit per
// SYM_CYCLES clocks, while channel_lock is high.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : register bus (slave side)
//   channel_lock : ADPLL lock indication
//   data_mod     : serial modulation bit
//   tx_busy      : sending with FIFO or shift register non-empty
module adpll_tx_serializer #(
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYM_CYCLES = 32,
  parameter bit          IDLE_BIT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  adpll_tx_serializer_if.slave bus,
  input  logic                 channel_lock,
  output logic                 data_mod,
  output logic                 tx_busy
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(SYM_CYCLES);
  localparam int unsigned BIT_W = $clog2(WORD_W) + 1;

  localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LOCK, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]    bits_q, bits_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                en_q, en_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;
  logic                lock_loss_q, lock_loss_d;
  logic                data_mod_q, data_mod_d;
  logic                tx_busy_q, tx_busy_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];

  logic                accept, push, pop, flush, clr, do_write;
  logic [15:0]         status;
  logic                unused_wdata;

  assign unused_wdata = ^bus.wdata;

  // Register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bits_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      en_q        <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      lock_loss_q <= 1'b0;
      data_mod_q  <= 1'b0;
      tx_busy_q   <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bits_q      <= bits_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      en_q        <= en_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      lock_loss_q <= lock_loss_d;
      data_mod_q  <= data_mod_d;
      tx_busy_q   <= tx_busy_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= bus.wdata[WORD_W-1:0];
  end

  // Bus decode, FSM, FIFO control and sticky flags
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bits_d      = bits_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    en_d        = en_q;
    underrun_d  = underrun_q;
    overflow_d  = overflow_q;
    lock_loss_d = lock_loss_q;
    data_mod_d  = data_mod_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    clr         = 1'b0;
    do_write    = 1'b0;

    status      = '0;
    status[0]    = (level_q == '0);
    status[1]    = (level_q == LVL_W'(FIFO_DEPTH));
    status[2]    = underrun_q;
    status[3]    = overflow_q;
    status[4]    = lock_loss_q;
    status[15:8] = 8'(level_q);

    // A held valid is taken again only after ready has dropped.
    accept = bus.valid && !ready_q;
    if (accept) begin
      ready_d = 1'b1;
      rdata_d = '0;
      if (bus.wstrb) begin
        case (bus.address)
          A_TX:   push = 1'b1;
          A_CTRL: begin
            en_d  = bus.wdata[0];
            clr   = bus.wdata[1];
            flush = bus.wdata[2];
          end
          default: ;
        endcase
      end else if (bus.address == A_STATUS) begin
        rdata_d = DATA_W'(status);
      end
    end

    // Clear first so a same-cycle event below leaves its flag set.
    if (clr) begin
      underrun_d  = 1'b0;
      overflow_d  = 1'b0;
      lock_loss_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        data_mod_d = 1'b0;
        cnt_d      = '0;
        bits_d     = '0;
        if (en_q) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        data_mod_d = 1'b0;
        cnt_d      = '0;
        if (!en_q)             state_d = S_IDLE;
        else if (channel_lock) state_d = S_SEND;
      end
      S_SEND: begin
        if (!en_q) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          bits_d     = '0;
          data_mod_d = 1'b0;
        end else if (!channel_lock) begin
          // Lock loss outranks a coinciding symbol boundary.
          state_d     = S_WAIT_LOCK;
          cnt_d       = '0;
          bits_d      = '0;
          data_mod_d  = 1'b0;
          lock_loss_d = 1'b1;
        end else if (cnt_q == CNT_W'(SYM_CYCLES - 1)) begin
          cnt_d = '0;
          if (bits_q != '0) begin
            data_mod_d = shift_q[0];
            shift_d    = shift_q >> 1;
            bits_d     = bits_q - BIT_W'(1);
          end else if ((level_q != '0) && !flush) begin
            pop        = 1'b1;
            data_mod_d = mem[rd_ptr_q][0];
            shift_d    = mem[rd_ptr_q] >> 1;
            bits_d     = BIT_W'(WORD_W - 1);
          end else begin
            data_mod_d = IDLE_BIT;
            underrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // FIFO pointers; a push into a full FIFO drops even if a pop coincides.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        if (level_q == LVL_W'(FIFO_DEPTH)) begin
          overflow_d = 1'b1;
        end else begin
          do_write = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(do_write) - LVL_W'(pop);
    end

    tx_busy_d = (state_d == S_SEND) && ((level_d != '0) || (bits_d != '0));
  end

  assign data_mod  = data_mod_q;
  assign tx_busy   = tx_busy_q;
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_adpll_tx_serializer.sv
// Self-checking bench for adpll_tx_serializer: a queue of expected data_mod
// bits is filled on TX_DATA writes and drained symbol by symbol.
module tb_adpll_tx_serializer;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SYM_CYCLES = 32;
  localparam bit          IDLE_BIT   = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic channel_lock = 1'b0;
  logic data_mod;
  logic tx_busy;

  int n_err = 0;
  int n_chk = 0;
  logic exp_q[$];

  adpll_tx_serializer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  adpll_tx_serializer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_W(WORD_W),
    .FIFO_DEPTH(FIFO_DEPTH), .SYM_CYCLES(SYM_CYCLES), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .channel_lock(channel_lock),
    .data_mod(data_mod),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with ready low again.
  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.valid = 1'b1; bus.wstrb = 1'b1; bus.address = a; bus.wdata = d;
    @(posedge clk); @(negedge clk);
    bus.valid = 1'b0; bus.wstrb = 1'b0;
    check_eq("wr_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check_eq("wr_ready_drop", 32'(bus.ready), 32'd0);
  endtask

  task automatic bus_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = a;
    @(posedge clk); @(negedge clk);
    bus.valid = 1'b0;
    check_eq({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check_eq(tag, bus.rdata, exp);
    @(negedge clk);
  endtask

  // Push a word; the scoreboard only takes it when the FIFO has room.
  task automatic push_word(input logic [WORD_W-1:0] w);
    int unsigned queued;
    queued = exp_q.size();
    bus_write(ADDR_W'(0), DATA_W'(w));
    if (queued < WORD_W * FIFO_DEPTH)
      for (int i = 0; i < int'(WORD_W); i++) exp_q.push_back(w[i]);
  endtask

  // Starts in the first cycle of a symbol; checks the last cycle of the
  // current value and the first cycle of the next one, n times.
  task automatic expect_bits(input int n, input logic prev_in);
    logic prev, want;
    prev = prev_in;
    for (int k = 0; k < n; k++) begin
      repeat (SYM_CYCLES - 1) @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("hold%0d", k), 32'(data_mod), 32'(prev));
      @(posedge clk); @(negedge clk);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_BIT;
      check_eq($sformatf("bit%0d", k), 32'(data_mod), 32'(want));
      prev = want;
    end
  endtask

  task automatic stop_and_clear();
    bus_write(ADDR_W'(1), DATA_W'(0));
    bus_write(ADDR_W'(1), DATA_W'(2));
    bus_read("st_cleared", ADDR_W'(2), 32'h01);
  endtask

  initial begin
    bus.valid = 1'b0; bus.wstrb = 1'b0; bus.address = '0; bus.wdata = '0;

    // Reset state
    #12;
    check_eq("rst_data_mod", 32'(data_mod), 32'd0);
    check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_ready", 32'(bus.ready), 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    bus_read("st_reset", ADDR_W'(2), 32'h01);
    bus_write(ADDR_W'(3), 32'hFFFF_FFFF);
    bus_read("rd_reserved", ADDR_W'(3), 32'h0);
    bus_read("rd_ctrl", ADDR_W'(1), 32'h0);

    // Single word 0xA5, then underrun
    channel_lock = 1'b1;
    push_word(8'hA5);
    bus_write(ADDR_W'(1), DATA_W'(1));
    @(posedge clk); @(negedge clk);
    check_eq("busy_send", 32'(tx_busy), 32'd1);
    expect_bits(9, 1'b0);
    bus_read("st_underrun", ADDR_W'(2), 32'h05);
    stop_and_clear();

    // Overflow with five words; fifth never sent
    push_word(8'h3C);
    push_word(8'h81);
    push_word(8'h5A);
    push_word(8'hF0);
    push_word(8'hFF);
    bus_read("st_overflow", ADDR_W'(2), 32'h040A);

    // Enabled without lock: nothing moves
    channel_lock = 1'b0;
    bus_write(ADDR_W'(1), DATA_W'(1));
    repeat (4) begin
      repeat (50) @(negedge clk);
      check_eq("nolock_data_mod", 32'(data_mod), 32'd0);
    end
    bus_read("st_nolock", ADDR_W'(2), 32'h040A);
    channel_lock = 1'b1;
    @(posedge clk); @(negedge clk);
    expect_bits(WORD_W * FIFO_DEPTH + 1, 1'b0);
    bus_read("st_drained", ADDR_W'(2), 32'h0D);
    stop_and_clear();

    // Lock loss after 3 bits of 0xFF
    push_word(8'hFF);
    push_word(8'h96);
    bus_write(ADDR_W'(1), DATA_W'(1));
    @(posedge clk); @(negedge clk);
    expect_bits(3, 1'b0);
    channel_lock = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("lockloss_data_mod", 32'(data_mod), 32'd0);
    repeat (5) void'(exp_q.pop_front());
    channel_lock = 1'b1;
    @(posedge clk); @(negedge clk);
    expect_bits(9, 1'b0);
    bus_read("st_lockloss", ADDR_W'(2), 32'h15);
    stop_and_clear();

    // Flush with three words queued
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    bus_read("st_three", ADDR_W'(2), 32'h0300);
    bus_write(ADDR_W'(1), DATA_W'(4));
    exp_q.delete();
    bus_read("st_flushed", ADDR_W'(2), 32'h01);

    // Reset mid-symbol while sending
    push_word(8'hA5);
    bus_write(ADDR_W'(1), DATA_W'(1));
    @(posedge clk); @(negedge clk);
    repeat (40) @(negedge clk);
    check_eq("pre_rst_data_mod", 32'(data_mod), 32'd1);
    check_eq("pre_rst_tx_busy", 32'(tx_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_data_mod", 32'(data_mod), 32'd0);
    check_eq("async_rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("async_rst_ready", 32'(bus.ready), 32'd0);
    check_eq("async_rst_rdata", bus.rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    bus_read("st_after_rst", ADDR_W'(2), 32'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
